// File: rtl/conv_kxk_stream_if.sv
// Handshake bundle for conv_kxk_stream: row-beat input channel and result output channel.
interface conv_kxk_stream_if #(
    parameter int BIT_LEN = 8,
    parameter int K_LEN   = 3,
    parameter int ACC_LEN = 2*BIT_LEN + $clog2(K_LEN*K_LEN)
) ();
    logic                     i_valid;
    logic                     o_ready;
    logic                     i_selecK_I;
    logic [K_LEN*BIT_LEN-1:0] i_data;
    logic                     o_kernel_rdy;
    logic                     o_valid;
    logic                     i_ready;
    logic [ACC_LEN-1:0]       o_data;

    modport slave (
        input  i_valid, i_selecK_I, i_data, i_ready,
        output o_ready, o_kernel_rdy, o_valid, o_data
    );

    modport master (
        output i_valid, i_selecK_I, i_data, i_ready,
        input  o_ready, o_kernel_rdy, o_valid, o_data
    );
endinterface

// File: rtl/conv_kxk_stream.sv
// KxK streaming convolution: kernel/image rows shift in one per beat, each full window
// produces one multiply-accumulate result through a two-stage stallable pipeline.
module conv_kxk_stream #(
    parameter int BIT_LEN = 8,
    parameter int K_LEN   = 3,
    parameter int SIGNED  = 1,
    parameter int ACC_LEN = 2*BIT_LEN + $clog2(K_LEN*K_LEN)
) (
    input logic              i_clk,
    input logic              i_reset,
    conv_kxk_stream_if.slave bus
);
    localparam int ROW_W  = K_LEN*BIT_LEN;
    localparam int PROD_W = 2*BIT_LEN;
    localparam int NPROD  = K_LEN*K_LEN;
    localparam int CNT_W  = $clog2(K_LEN+1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN-1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [K_LEN-1:0][ROW_W-1:0]   kern_q, kern_d;
    logic [K_LEN-1:0][ROW_W-1:0]   img_q, img_d;
    logic [CNT_W-1:0]              kcnt_q, kcnt_d;
    logic [CNT_W-1:0]              icnt_q, icnt_d;
    logic                          krdy_q;
    logic [NPROD-1:0][PROD_W-1:0]  prod_q, prod_d;
    logic                          p1_valid_q;
    logic                          out_valid_q;
    logic [ACC_LEN-1:0]            out_data_q, sum_d;
    logic                          stall_s, accept_s, fire_s;

    function automatic logic [PROD_W-1:0] ext_operand(input logic [BIT_LEN-1:0] v);
        logic fill_s;
        fill_s = (SIGNED != 0) ? v[BIT_LEN-1] : 1'b0;
        return {{BIT_LEN{fill_s}}, v};
    endfunction

    function automatic logic [ACC_LEN-1:0] ext_product(input logic [PROD_W-1:0] p);
        logic fill_s;
        fill_s = (SIGNED != 0) ? p[PROD_W-1] : 1'b0;
        return {{(ACC_LEN-PROD_W){fill_s}}, p};
    endfunction

    assign stall_s  = out_valid_q & ~bus.i_ready;
    assign accept_s = bus.i_valid & ~stall_s;

    // Row shifting, load-state tracking and result firing for an accepted beat
    always_comb begin
        state_d = state_q;
        kern_d  = kern_q;
        img_d   = img_q;
        kcnt_d  = kcnt_q;
        icnt_d  = icnt_q;
        fire_s  = 1'b0;
        if (accept_s) begin
            if (!bus.i_selecK_I) begin
                kern_d = {bus.i_data, kern_q[K_LEN-1:1]};
                if (state_q == ST_EMPTY) begin
                    kcnt_d  = kcnt_q + CNT_ONE;
                    state_d = (kcnt_q == CNT_LAST) ? ST_FILL : ST_EMPTY;
                end else begin
                    // A kernel beat after completion starts a fresh kernel and empties the window
                    kcnt_d  = CNT_ONE;
                    icnt_d  = {CNT_W{1'b0}};
                    state_d = ST_EMPTY;
                end
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        img_d = img_q;
                    end
                    ST_FILL: begin
                        img_d  = {bus.i_data, img_q[K_LEN-1:1]};
                        icnt_d = icnt_q + CNT_ONE;
                        if (icnt_q == CNT_LAST) begin
                            state_d = ST_RUN;
                            fire_s  = 1'b1;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                    ST_RUN: begin
                        img_d  = {bus.i_data, img_q[K_LEN-1:1]};
                        fire_s = 1'b1;
                    end
                    default: begin
                        state_d = ST_EMPTY;
                        kcnt_d  = {CNT_W{1'b0}};
                        icnt_d  = {CNT_W{1'b0}};
                    end
                endcase
            end
        end else begin
            fire_s = 1'b0;
        end
    end

    // Element products over the window including the row accepted this cycle
    always_comb begin
        prod_d = '0;
        for (int r = 0; r < K_LEN; r++) begin
            for (int c = 0; c < K_LEN; c++) begin
                prod_d[r*K_LEN + c] = ext_operand(kern_d[r][c*BIT_LEN +: BIT_LEN])
                                    * ext_operand(img_d[r][c*BIT_LEN +: BIT_LEN]);
            end
        end
    end

    // Adder tree over the registered products
    always_comb begin
        sum_d = {ACC_LEN{1'b0}};
        for (int p = 0; p < NPROD; p++) begin
            sum_d = sum_d + ext_product(prod_q[p]);
        end
    end

    // State, row storage and both pipeline stages
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_EMPTY;
            kern_q      <= '0;
            img_q       <= '0;
            kcnt_q      <= {CNT_W{1'b0}};
            icnt_q      <= {CNT_W{1'b0}};
            krdy_q      <= 1'b0;
            prod_q      <= '0;
            p1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_LEN{1'b0}};
        end else begin
            state_q <= state_d;
            kern_q  <= kern_d;
            img_q   <= img_d;
            kcnt_q  <= kcnt_d;
            icnt_q  <= icnt_d;
            krdy_q  <= (state_d != ST_EMPTY);
            if (!stall_s) begin
                p1_valid_q  <= fire_s;
                out_valid_q <= p1_valid_q;
                if (fire_s) begin
                    prod_q <= prod_d;
                end
                if (p1_valid_q) begin
                    out_data_q <= sum_d;
                end
            end
        end
    end

    assign bus.o_ready      = ~stall_s;
    assign bus.o_kernel_rdy = krdy_q;
    assign bus.o_valid      = out_valid_q;
    assign bus.o_data       = out_data_q;
endmodule

// File: tb/tb_conv_kxk_stream.sv
// Scoreboard bench for conv_kxk_stream: signed and unsigned 3x3 engines share stimulus,
// a 5x5/4-bit instance covers a second parameter set.
module tb_conv_kxk_stream;
    logic clk_s = 1'b0;
    logic rst_s;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_s = ~clk_s;

    conv_kxk_stream_if #(.BIT_LEN(8), .K_LEN(3), .ACC_LEN(20)) bs ();
    conv_kxk_stream_if #(.BIT_LEN(8), .K_LEN(3), .ACC_LEN(20)) bu ();
    conv_kxk_stream_if #(.BIT_LEN(4), .K_LEN(5), .ACC_LEN(13)) b5 ();

    conv_kxk_stream #(.BIT_LEN(8), .K_LEN(3), .SIGNED(1), .ACC_LEN(20)) dut_s (
        .i_clk(clk_s), .i_reset(rst_s), .bus(bs));
    conv_kxk_stream #(.BIT_LEN(8), .K_LEN(3), .SIGNED(0), .ACC_LEN(20)) dut_u (
        .i_clk(clk_s), .i_reset(rst_s), .bus(bu));
    conv_kxk_stream #(.BIT_LEN(4), .K_LEN(5), .SIGNED(1), .ACC_LEN(13)) dut_5 (
        .i_clk(clk_s), .i_reset(rst_s), .bus(b5));

    assign bu.i_valid    = bs.i_valid;
    assign bu.i_selecK_I = bs.i_selecK_I;
    assign bu.i_data     = bs.i_data;
    assign bu.i_ready    = bs.i_ready;

    // reference model state
    logic [7:0]  mk [3][3];
    logic [7:0]  mi [3][3];
    int          mkcnt, micnt;
    bit          mkrdy;
    logic [19:0] qs [$];
    logic [19:0] qu [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [23:0] rw(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {c, b, a};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                mk[r][c] = 8'd0;
                mi[r][c] = 8'd0;
            end
        end
        mkcnt = 0;
        micnt = 0;
        mkrdy = 1'b0;
    endtask

    task automatic push_expected();
        int ss = 0;
        int su = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                ss += int'($signed(mk[r][c])) * int'($signed(mi[r][c]));
                su += int'(mk[r][c]) * int'(mi[r][c]);
            end
        end
        qs.push_back(20'(ss));
        qu.push_back(20'(su));
    endtask

    task automatic model_beat(input bit sel, input logic [23:0] row);
        if (!sel) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 3; c++) mk[r][c] = mk[r+1][c];
            for (int c = 0; c < 3; c++) mk[2][c] = row[c*8 +: 8];
            if (!mkrdy) begin
                mkcnt++;
                if (mkcnt == 3) mkrdy = 1'b1;
            end else begin
                mkcnt = 1;
                micnt = 0;
                mkrdy = 1'b0;
            end
        end else if (mkrdy) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 3; c++) mi[r][c] = mi[r+1][c];
            for (int c = 0; c < 3; c++) mi[2][c] = row[c*8 +: 8];
            if (micnt < 3) micnt++;
            if (micnt == 3) push_expected();
        end
    endtask

    // Scoreboard monitor, sampled on the inactive edge
    always @(negedge clk_s) begin
        if (rst_s) begin
            model_reset();
            qs.delete();
            qu.delete();
        end else begin
            check_eq("kernel_rdy", 32'(bs.o_kernel_rdy), 32'(mkrdy));
            check_eq("ready_vs_stall", 32'(bs.o_ready), 32'(!(bs.o_valid && !bs.i_ready)));
            if (bs.o_valid && bs.i_ready) begin
                check_eq("sb_pending_s", 32'(qs.size() != 0), 32'd1);
                if (qs.size() != 0) check_eq("result_s", 32'(bs.o_data), 32'(qs.pop_front()));
            end
            if (bu.o_valid && bu.i_ready) begin
                check_eq("sb_pending_u", 32'(qu.size() != 0), 32'd1);
                if (qu.size() != 0) check_eq("result_u", 32'(bu.o_data), 32'(qu.pop_front()));
            end
            if (bs.i_valid && bs.o_ready) model_beat(bs.i_selecK_I, bs.i_data);
        end
    end

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic beat(input bit sel, input logic [23:0] row);
        int guard = 0;
        bs.i_valid    = 1'b1;
        bs.i_selecK_I = sel;
        bs.i_data     = row;
        @(negedge clk_s);
        while (!bs.o_ready && guard < 50) begin
            guard++;
            @(negedge clk_s);
        end
        if (guard >= 50) check_eq("beat_accept_timeout", 32'(guard), 32'd0);
        tick();
    endtask

    task automatic idle();
        bs.i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_s      = 1'b1;
        bs.i_valid = 1'b0;
        b5.i_valid = 1'b0;
        tick();
        tick();
        rst_s = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk_s);
        while (!bs.o_valid && n < 10) begin
            n++;
            @(negedge clk_s);
        end
        check_eq({tag, "_valid"}, 32'(bs.o_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((qs.size() != 0 || qu.size() != 0) && n < 20) begin
            n++;
            tick();
        end
        check_eq({tag, "_drain_s"}, 32'(qs.size()), 32'd0);
        check_eq({tag, "_drain_u"}, 32'(qu.size()), 32'd0);
    endtask

    task automatic scenario_ones(input string tag);
        for (int i = 0; i < 3; i++) beat(1'b0, rw(8'd1, 8'd1, 8'd1));
        idle();
        @(negedge clk_s);
        check_eq({tag, "_krdy"}, 32'(bs.o_kernel_rdy), 32'd1);
        tick();
        beat(1'b1, rw(8'd1, 8'd2, 8'd3));
        beat(1'b1, rw(8'd4, 8'd5, 8'd6));
        beat(1'b1, rw(8'd7, 8'd8, 8'd9));
        idle();
        @(negedge clk_s);
        check_eq({tag, "_lat1_valid"}, 32'(bs.o_valid), 32'd0);
        @(negedge clk_s);
        check_eq({tag, "_lat2_valid"}, 32'(bs.o_valid), 32'd1);
        check_eq({tag, "_data_s"}, 32'(bs.o_data), 32'd45);
        check_eq({tag, "_data_u"}, 32'(bu.o_data), 32'd45);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] row_v;
        rst_s         = 1'b1;
        bs.i_valid    = 1'b0;
        bs.i_selecK_I = 1'b0;
        bs.i_data     = 24'd0;
        bs.i_ready    = 1'b1;
        b5.i_valid    = 1'b0;
        b5.i_selecK_I = 1'b0;
        b5.i_data     = 20'd0;
        b5.i_ready    = 1'b1;
        model_reset();
        tick();
        do_reset();

        // reset state
        @(negedge clk_s);
        check_eq("rst_valid", 32'(bs.o_valid), 32'd0);
        check_eq("rst_data", 32'(bs.o_data), 32'd0);
        check_eq("rst_krdy", 32'(bs.o_kernel_rdy), 32'd0);
        check_eq("rst_ready", 32'(bs.o_ready), 32'd1);
        tick();

        // 1: ones kernel over 1..9
        scenario_ones("t1");

        // 2: -1 kernel over 127 image, signed and unsigned
        do_reset();
        for (int i = 0; i < 3; i++) beat(1'b0, 24'hFFFFFF);
        for (int i = 0; i < 3; i++) beat(1'b1, 24'h7F7F7F);
        idle();
        wait_valid("t2");
        check_eq("t2_data_s", 32'(bs.o_data), 32'(20'hFFB89));
        check_eq("t2_data_u", 32'(bu.o_data), 32'd291465);
        tick();

        // 3: all 0xFF then a zero row back-to-back
        do_reset();
        for (int i = 0; i < 3; i++) beat(1'b0, 24'hFFFFFF);
        for (int i = 0; i < 3; i++) beat(1'b1, 24'hFFFFFF);
        beat(1'b1, 24'h000000);
        idle();
        @(negedge clk_s);
        check_eq("t3_valid0", 32'(bs.o_valid), 32'd1);
        check_eq("t3_data0_u", 32'(bu.o_data), 32'd585225);
        check_eq("t3_data0_s", 32'(bs.o_data), 32'd9);
        @(negedge clk_s);
        check_eq("t3_valid1", 32'(bs.o_valid), 32'd1);
        check_eq("t3_data1_u", 32'(bu.o_data), 32'd390150);
        check_eq("t3_data1_s", 32'(bs.o_data), 32'd6);
        tick();

        // 4: backpressure while streaming
        do_reset();
        for (int i = 0; i < 3; i++) beat(1'b0, 24'($urandom));
        for (int i = 0; i < 4; i++) beat(1'b1, 24'($urandom));
        row_v         = 24'($urandom);
        bs.i_valid    = 1'b1;
        bs.i_selecK_I = 1'b1;
        bs.i_data     = row_v;
        bs.i_ready    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_s);
            check_eq("t4_stall_ready", 32'(bs.o_ready), 32'd0);
            check_eq("t4_stall_valid", 32'(bs.o_valid), 32'd1);
            check_eq("t4_stall_qs", 32'(qs.size() != 0), 32'd1);
            if (qs.size() != 0) check_eq("t4_hold_s", 32'(bs.o_data), 32'(qs[0]));
            if (qu.size() != 0) check_eq("t4_hold_u", 32'(bu.o_data), 32'(qu[0]));
            tick();
        end
        bs.i_ready = 1'b1;
        beat(1'b1, row_v);
        for (int i = 0; i < 3; i++) beat(1'b1, 24'($urandom));
        idle();
        drain("t4");

        // 5: image before kernel, then kernel reload while running
        do_reset();
        beat(1'b1, 24'($urandom));
        beat(1'b1, 24'($urandom));
        idle();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) beat(1'b0, 24'($urandom));
        for (int i = 0; i < 4; i++) beat(1'b1, 24'($urandom));
        beat(1'b0, 24'($urandom));
        idle();
        @(negedge clk_s);
        check_eq("t5_reload_krdy", 32'(bs.o_kernel_rdy), 32'd0);
        tick();
        beat(1'b1, 24'($urandom));
        beat(1'b0, 24'($urandom));
        beat(1'b0, 24'($urandom));
        beat(1'b1, 24'($urandom));
        beat(1'b1, 24'($urandom));
        idle();
        drain("t5a");
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk_s);
        check_eq("t5_no_early", 32'(bs.o_valid), 32'd0);
        tick();
        beat(1'b1, 24'($urandom));
        idle();
        wait_valid("t5");
        tick();
        drain("t5b");

        // 6: reset with a result on the output and a beat in flight
        do_reset();
        for (int i = 0; i < 3; i++) beat(1'b0, 24'($urandom));
        for (int i = 0; i < 3; i++) beat(1'b1, 24'($urandom));
        idle();
        tick();
        rst_s         = 1'b1;
        bs.i_valid    = 1'b1;
        bs.i_selecK_I = 1'b0;
        bs.i_data     = 24'($urandom);
        @(negedge clk_s);
        check_eq("t6_valid_before", 32'(bs.o_valid), 32'd1);
        tick();
        rst_s = 1'b0;
        idle();
        @(negedge clk_s);
        check_eq("t6_valid", 32'(bs.o_valid), 32'd0);
        check_eq("t6_data", 32'(bs.o_data), 32'd0);
        check_eq("t6_krdy", 32'(bs.o_kernel_rdy), 32'd0);
        check_eq("t6_valid_u", 32'(bu.o_valid), 32'd0);
        tick();
        scenario_ones("t6r");

        // 5x5 / 4-bit instance, all ones
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b5.i_valid    = 1'b1;
            b5.i_selecK_I = (i >= 5);
            b5.i_data     = 20'h11111;
            tick();
        end
        b5.i_valid = 1'b0;
        begin
            int n = 0;
            @(negedge clk_s);
            while (!b5.o_valid && n < 10) begin
                n++;
                @(negedge clk_s);
            end
            check_eq("k5_valid", 32'(b5.o_valid), 32'd1);
            check_eq("k5_krdy", 32'(b5.o_kernel_rdy), 32'd1);
            check_eq("k5_data", 32'(b5.o_data), 32'd25);
        end
        tick();

        drain("end");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
